// File: rtl/mac_mul_arbiter_if.sv
// Requester, response and control bundle for the shared multiplier.
// Slave side is the arbiter; master side is requesters plus consumer.
interface mac_mul_arbiter_if #(
    parameter int PARM_TAG = 2
);
    logic                req0_valid_i;
    logic [PARM_TAG-1:0] req0_tag_i;
    logic                req0_ready_o;
    logic                req1_valid_i;
    logic [PARM_TAG-1:0] req1_tag_i;
    logic                req1_ready_o;
    logic                flush_i;
    logic                issue_sel_o;
    logic [2:0]          stage_en_o;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic                rsp_src_o;
    logic [PARM_TAG-1:0] rsp_tag_o;
    logic                busy_o;

    modport slave (
        input  req0_valid_i, req0_tag_i,
        output req0_ready_o,
        input  req1_valid_i, req1_tag_i,
        output req1_ready_o,
        input  flush_i,
        output issue_sel_o, stage_en_o,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_src_o, rsp_tag_o, busy_o
    );

    modport master (
        output req0_valid_i, req0_tag_i,
        input  req0_ready_o,
        output req1_valid_i, req1_tag_i,
        input  req1_ready_o,
        output flush_i,
        input  issue_sel_o, stage_en_o,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_src_o, rsp_tag_o, busy_o
    );
endinterface

// File: rtl/mac_mul_arbiter.sv
// Round-robin issue arbiter and stall control for a 3-stage multiplier
// shared by the integer MUL (req0) and FP FMA (req1) units.
module mac_mul_arbiter #(
    parameter int PARM_TAG = 2,
    parameter int PARM_LAT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mac_mul_arbiter_if.slave     bus
);
    localparam int N = PARM_LAT;

    logic [N-1:0]                v;
    logic [N-1:0]                src;
    logic [N-1:0][PARM_TAG-1:0]  tag;
    logic                        last_grant;

    logic                        stall2;
    logic                        stall1;
    logic [N-1:0]                en;
    logic                        can_issue;
    logic                        ready0;
    logic                        ready1;
    logic                        grant0;
    logic                        grant1;
    logic                        issue;

    // Stall chain with bubble collapse, then round-robin grant.
    // Readies never look at their own valid, only at the peer's.
    always_comb begin
        stall2    = v[2] & ~bus.rsp_ready_i;
        stall1    = stall2 & v[1];
        en        = '1;
        en[2]     = ~stall2;
        en[1]     = ~stall1;
        en[0]     = ~(stall1 & v[0]);
        can_issue = en[0] & ~bus.flush_i & ~rst_i;
        ready0    = can_issue & (~bus.req1_valid_i | last_grant);
        ready1    = can_issue & (~bus.req0_valid_i | ~last_grant);
        grant0    = ready0 & bus.req0_valid_i;
        grant1    = ready1 & bus.req1_valid_i;
        issue     = grant0 | grant1;
    end

    assign bus.req0_ready_o = ready0;
    assign bus.req1_ready_o = ready1;
    assign bus.issue_sel_o  = grant1;
    assign bus.stage_en_o   = en;
    assign bus.rsp_valid_o  = v[2];
    assign bus.rsp_src_o    = src[2];
    assign bus.rsp_tag_o    = tag[2];
    assign bus.busy_o       = |v;

    // Advance loading stages; flush overrides every valid bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v          <= '0;
            src        <= '0;
            tag        <= '0;
            last_grant <= 1'b1;
        end else begin
            if (issue) begin
                last_grant <= grant1;
            end
            if (en[2]) begin
                v[2]   <= v[1];
                src[2] <= src[1];
                tag[2] <= tag[1];
            end
            if (en[1]) begin
                v[1]   <= v[0];
                src[1] <= src[0];
                tag[1] <= tag[0];
            end
            if (en[0]) begin
                v[0]   <= issue;
                src[0] <= grant1;
                tag[0] <= grant1 ? bus.req1_tag_i : bus.req0_tag_i;
            end
            if (bus.flush_i) begin
                v <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mac_mul_arbiter.sv
// Directed bench for mac_mul_arbiter: issue, alternation, stall,
// bubble collapse, flush and asynchronous reset.
module tb_mac_mul_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mac_mul_arbiter_if #(.PARM_TAG(2)) bus ();

    mac_mul_arbiter #(.PARM_TAG(2), .PARM_LAT(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Linear directed sequence.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0_valid_i = 1'b1;
        bus.req0_tag_i   = 2'd0;
        bus.req1_valid_i = 1'b0;
        bus.req1_tag_i   = 2'd0;
        bus.flush_i      = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        #3;
        chk("rst_rsp_valid", 8'(bus.rsp_valid_o), 8'd0);
        chk("rst_busy", 8'(bus.busy_o), 8'd0);
        chk("rst_ready0", 8'(bus.req0_ready_o), 8'd0);
        chk("rst_ready1", 8'(bus.req1_ready_o), 8'd0);
        step();
        rst = 1'b0;
        bus.req0_valid_i = 1'b0;

        // Single req1 issue, tag 2
        bus.req1_valid_i = 1'b1;
        bus.req1_tag_i   = 2'd2;
        #1;
        chk("a_ready1", 8'(bus.req1_ready_o), 8'd1);
        chk("a_sel", 8'(bus.issue_sel_o), 8'd1);
        chk("a_en", 8'(bus.stage_en_o), 8'b111);
        step();
        bus.req1_valid_i = 1'b0;
        #1;
        chk("a_busy1", 8'(bus.busy_o), 8'd1);
        chk("a_rv1", 8'(bus.rsp_valid_o), 8'd0);
        step();
        chk("a_busy2", 8'(bus.busy_o), 8'd1);
        chk("a_rv2", 8'(bus.rsp_valid_o), 8'd0);
        step();
        chk("a_rv3", 8'(bus.rsp_valid_o), 8'd1);
        chk("a_src3", 8'(bus.rsp_src_o), 8'd1);
        chk("a_tag3", 8'(bus.rsp_tag_o), 8'd2);
        chk("a_busy3", 8'(bus.busy_o), 8'd1);
        step();
        chk("a_busy4", 8'(bus.busy_o), 8'd0);
        chk("a_rv4", 8'(bus.rsp_valid_o), 8'd0);

        // Both valid: alternate grants, tag = issue cycle mod 4
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid_i = 1'b1;
            bus.req1_valid_i = 1'b1;
            bus.req0_tag_i   = 2'(i);
            bus.req1_tag_i   = 2'(i);
            #1;
            chk("b_ready0", 8'(bus.req0_ready_o), 8'((i % 2) == 0));
            chk("b_ready1", 8'(bus.req1_ready_o), 8'((i % 2) == 1));
            if (i >= 3) begin
                chk("b_rv", 8'(bus.rsp_valid_o), 8'd1);
                chk("b_src", 8'(bus.rsp_src_o), 8'((i - 3) % 2));
                chk("b_tag", 8'(bus.rsp_tag_o), 8'((i - 3) % 4));
            end
            step();
        end

        // Full pipeline stalled for 4 cycles
        bus.rsp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("c_en", 8'(bus.stage_en_o), 8'b000);
            chk("c_ready0", 8'(bus.req0_ready_o), 8'd0);
            chk("c_ready1", 8'(bus.req1_ready_o), 8'd0);
            chk("c_rv", 8'(bus.rsp_valid_o), 8'd1);
            chk("c_tag", 8'(bus.rsp_tag_o), 8'd3);
            chk("c_src", 8'(bus.rsp_src_o), 8'd1);
            step();
        end
        bus.rsp_ready_i  = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        #1;
        chk("c_drain_tag0", 8'(bus.rsp_tag_o), 8'd3);
        chk("c_drain_src0", 8'(bus.rsp_src_o), 8'd1);
        step();
        chk("c_drain_rv1", 8'(bus.rsp_valid_o), 8'd1);
        chk("c_drain_tag1", 8'(bus.rsp_tag_o), 8'd0);
        chk("c_drain_src1", 8'(bus.rsp_src_o), 8'd0);
        step();
        chk("c_drain_rv2", 8'(bus.rsp_valid_o), 8'd1);
        chk("c_drain_tag2", 8'(bus.rsp_tag_o), 8'd1);
        chk("c_drain_src2", 8'(bus.rsp_src_o), 8'd1);
        step();
        chk("c_empty_rv", 8'(bus.rsp_valid_o), 8'd0);
        chk("c_empty_busy", 8'(bus.busy_o), 8'd0);

        // Bubble in stage 1 under a stage-2 stall
        bus.req0_valid_i = 1'b1;
        bus.req0_tag_i   = 2'd0;
        #1;
        chk("d_ready0", 8'(bus.req0_ready_o), 8'd1);
        step();
        bus.req0_valid_i = 1'b0;
        step();
        bus.req0_valid_i = 1'b1;
        bus.req0_tag_i   = 2'd1;
        step();
        bus.req0_valid_i = 1'b0;
        bus.rsp_ready_i  = 1'b0;
        bus.req1_valid_i = 1'b1;
        bus.req1_tag_i   = 2'd2;
        #1;
        chk("d_en", 8'(bus.stage_en_o), 8'b011);
        chk("d_ready1", 8'(bus.req1_ready_o), 8'd1);
        chk("d_rv", 8'(bus.rsp_valid_o), 8'd1);
        chk("d_tag", 8'(bus.rsp_tag_o), 8'd0);
        step();
        bus.req1_valid_i = 1'b0;
        #1;
        chk("d_en_full", 8'(bus.stage_en_o), 8'b000);
        chk("d_tag_hold", 8'(bus.rsp_tag_o), 8'd0);

        // Flush with 3 in flight and a coincident request
        bus.rsp_ready_i  = 1'b1;
        bus.flush_i      = 1'b1;
        bus.req0_valid_i = 1'b1;
        #1;
        chk("e_ready0", 8'(bus.req0_ready_o), 8'd0);
        chk("e_ready1", 8'(bus.req1_ready_o), 8'd0);
        step();
        bus.flush_i      = 1'b0;
        bus.req0_valid_i = 1'b0;
        #1;
        chk("e_busy", 8'(bus.busy_o), 8'd0);
        chk("e_rv", 8'(bus.rsp_valid_o), 8'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("e_no_rsp", 8'(bus.rsp_valid_o), 8'd0);
        end

        // Async reset mid-stream; last grant before reset is req0
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        bus.req0_tag_i   = 2'd1;
        bus.req1_tag_i   = 2'd2;
        #1;
        chk("f_ready0", 8'(bus.req0_ready_o), 8'd1);
        step();
        step();
        step();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        #1;
        chk("f_rv", 8'(bus.rsp_valid_o), 8'd1);
        chk("f_src", 8'(bus.rsp_src_o), 8'd0);
        chk("f_tag", 8'(bus.rsp_tag_o), 8'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("f_rst_rv", 8'(bus.rsp_valid_o), 8'd0);
        chk("f_rst_busy", 8'(bus.busy_o), 8'd0);
        step();
        rst = 1'b0;
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        #1;
        chk("f_tie_ready0", 8'(bus.req0_ready_o), 8'd1);
        chk("f_tie_ready1", 8'(bus.req1_ready_o), 8'd0);
        chk("f_tie_sel", 8'(bus.issue_sel_o), 8'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
